// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot loader: FSM state encoding, default
// program-memory depth and the width of the loaded-word counter.
// No ports (package).
// ---------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CHK     = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } state_t;

    // Program-memory depth in 16-bit words (power of two, at most 256).
    localparam int BOOT_DEPTH_DEF = 256;

    // Count width must hold DEPTH itself, hence 9 bits for 256 words.
    localparam int CNT_W = 9;

endpackage

// File: rtl/boot_ram.sv
// ---------------------------------------------------------------------------
// boot_ram
// DEPTH x 16 program memory: one synchronous write port, one asynchronous
// read port. Contents are not reset.
// Ports:
//   clk      - system clock (write on rising edge)
//   i_we     - write enable
//   i_waddr  - write word index
//   i_wdata  - write data
//   i_raddr  - read word index
//   o_rdata  - read data (combinational)
// ---------------------------------------------------------------------------
module boot_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
// Receives a boot image as a byte stream (16-bit big-endian length in words,
// then the words high byte first), stores it in program memory, and releases
// the CPU from reset once the whole image is in. The CPU fetches words
// through a zero-latency read port gated by the number of words loaded.
//
// Build option: define CHECKSUM_EN to append a one-byte XOR checksum over
// all data bytes after the image; a mismatch rejects the image.
//
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-low reset
//   rx_data      - boot-stream byte
//   rx_valid     - rx_data valid
//   rx_ready     - loader can accept a byte
//   address_bus  - CPU fetch address (word index)
//   data_bus     - word returned to the CPU
//   cpu_reset    - active-low reset to the CPU (1 = released)
//   load_done    - image loaded and CPU released
//   load_err     - image rejected
//   words_loaded - number of words written so far
//
// state   | meaning
// --------+---------------------------------------------------------
// LEN_HI  | waiting for length high byte
// LEN_LO  | waiting for length low byte, then range check of N
// DATA_HI | waiting for high byte of next word
// DATA_LO | waiting for low byte; word written on acceptance
// CHK     | waiting for checksum byte (CHECKSUM_EN only)
// RUN     | image accepted, CPU released; stream ignored
// ERR     | image rejected; stream ignored
// ---------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH = BOOT_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [15:0]      address_bus,
    output logic [15:0]      data_bus,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_len_hi;
    logic [CNT_W-1:0] r_len;
    logic [7:0]       r_hi;
    logic [CNT_W-1:0] r_words;
    logic             r_cpu_reset;
    logic             r_load_done;
    logic             r_load_err;
`ifdef CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    logic             w_rx_ready;
    logic             w_accept;
    logic             w_we;
    logic [15:0]      w_len_full;
    logic [CNT_W-1:0] w_words_inc;
    logic [15:0]      w_rdata;

    assign w_rx_ready  = (r_state != RUN) && (r_state != ERR);
    assign w_accept    = rx_valid && w_rx_ready;
    assign w_len_full  = {r_len_hi, rx_data};
    assign w_words_inc = r_words + CNT_W'(1);

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        case (r_state)
            LEN_HI: begin
                if (w_accept) w_state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (w_accept) begin
                    if (w_len_full == 16'd0 || w_len_full > DEPTH_W)
                        w_state_nxt = ERR;
                    else
                        w_state_nxt = DATA_HI;
                end
            end
            DATA_HI: begin
                if (w_accept) w_state_nxt = DATA_LO;
            end
            DATA_LO: begin
                if (w_accept) begin
                    w_we = 1'b1;
                    if (w_words_inc < r_len)
                        w_state_nxt = DATA_HI;
                    else
`ifdef CHECKSUM_EN
                        w_state_nxt = CHK;
`else
                        w_state_nxt = RUN;
`endif
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                if (w_accept)
                    w_state_nxt = (rx_data == r_csum) ? RUN : ERR;
            end
`endif
            RUN:     w_state_nxt = RUN;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = LEN_HI;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= LEN_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- Datapath and registered status ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_hi    <= 8'h00;
            r_len       <= '0;
            r_hi        <= 8'h00;
            r_words     <= '0;
            r_cpu_reset <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            // Decoded from the next state so the flags line up with the state.
            r_cpu_reset <= (w_state_nxt == RUN);
            r_load_done <= (w_state_nxt == RUN);
            r_load_err  <= (w_state_nxt == ERR);
            if (w_accept) begin
                case (r_state)
                    LEN_HI:  r_len_hi <= rx_data;
                    // Out-of-range lengths go to ERR, so truncation is safe.
                    LEN_LO:  r_len    <= w_len_full[CNT_W-1:0];
                    DATA_HI: r_hi     <= rx_data;
                    DATA_LO: r_words  <= w_words_inc;
                    default: ;
                endcase
`ifdef CHECKSUM_EN
                if (r_state == DATA_HI || r_state == DATA_LO)
                    r_csum <= r_csum ^ rx_data;
`endif
            end
        end
    end

    boot_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_words[AW-1:0]),
        .i_wdata ({r_hi, rx_data}),
        .i_raddr (address_bus[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // Words at or beyond the load count read as zero, hiding stale contents
    // left over from a previous image.
    assign data_bus     = (address_bus < {{(16-CNT_W){1'b0}}, r_words}) ? w_rdata : 16'h0000;
    assign rx_ready     = w_rx_ready;
    assign cpu_reset    = r_cpu_reset;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] address_bus;
    logic [15:0] data_bus;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    always #5 clk = ~clk;

    boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .address_bus  (address_bus),
        .data_bus     (data_bus),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    typedef enum {S_LOAD, S_RUN, S_ERR} exp_st_t;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [7:0]  d;
        logic [15:0] a;
        exp_st_t     st;
        logic [8:0]  words;
        logic [15:0] q;
    } vec_t;

    vec_t vq[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // {rx_ready, cpu_reset, load_done, load_err}
    function automatic logic [3:0] st_flags(input exp_st_t s);
        case (s)
            S_RUN:   return 4'b0110;
            S_ERR:   return 4'b0001;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic void pv(input logic rst_n, input logic vld, input logic [7:0] d,
                               input logic [15:0] a, input exp_st_t st,
                               input logic [8:0] words, input logic [15:0] q);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.d = d; v.a = a;
        v.st = st; v.words = words; v.q = q;
        vq.push_back(v);
    endfunction

    function automatic void rst();
        pv(1'b0, 1'b0, 8'h00, 16'h0000, S_LOAD, 9'd0, 16'h0000);
        pv(1'b1, 1'b0, 8'h00, 16'h0000, S_LOAD, 9'd0, 16'h0000);
    endfunction

    function automatic void by(input logic [7:0] d, input exp_st_t st,
                               input logic [8:0] w, input logic [15:0] q);
        pv(1'b1, 1'b1, d, 16'h0000, st, w, q);
    endfunction

    function automatic void idle(input logic [7:0] d, input exp_st_t st,
                                 input logic [8:0] w, input logic [15:0] q);
        pv(1'b1, 1'b0, d, 16'h0000, st, w, q);
    endfunction

    function automatic void rd(input logic [15:0] a, input exp_st_t st,
                               input logic [8:0] w, input logic [15:0] q);
        pv(1'b1, 1'b0, 8'h00, a, st, w, q);
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b1; rx_data = b; address_bus = 16'h0000;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] csum;
        logic [7:0] hi;
        logic [7:0] lo;

        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; address_bus = 16'h0000;

        // A: good 2-word image
        rst();
        by(8'h00, S_LOAD, 9'd0, 16'h0000);
        by(8'h02, S_LOAD, 9'd0, 16'h0000);
        by(8'h12, S_LOAD, 9'd0, 16'h0000);
        by(8'h34, S_LOAD, 9'd1, 16'h1234);
        by(8'hAB, S_LOAD, 9'd1, 16'h1234);
`ifdef CHECKSUM_EN
        by(8'hCD, S_LOAD, 9'd2, 16'h1234);
        by(8'h40, S_RUN,  9'd2, 16'h1234);
`else
        by(8'hCD, S_RUN,  9'd2, 16'h1234);
`endif
        rd(16'd0, S_RUN, 9'd2, 16'h1234);
        rd(16'd1, S_RUN, 9'd2, 16'hABCD);
        rd(16'd2, S_RUN, 9'd2, 16'h0000);

        // B: same image, wrong checksum byte
        rst();
        by(8'h00, S_LOAD, 9'd0, 16'h0000);
        by(8'h02, S_LOAD, 9'd0, 16'h0000);
        by(8'h12, S_LOAD, 9'd0, 16'h0000);
        by(8'h34, S_LOAD, 9'd1, 16'h1234);
        by(8'hAB, S_LOAD, 9'd1, 16'h1234);
`ifdef CHECKSUM_EN
        by(8'hCD, S_LOAD, 9'd2, 16'h1234);
        by(8'h41, S_ERR,  9'd2, 16'h1234);
        rd(16'd1, S_ERR,  9'd2, 16'hABCD);
`else
        by(8'hCD, S_RUN,  9'd2, 16'h1234);
        by(8'h41, S_RUN,  9'd2, 16'h1234);
`endif

        // C: length boundaries
        rst();
        by(8'h00, S_LOAD, 9'd0, 16'h0000);
        by(8'h00, S_ERR,  9'd0, 16'h0000);
        by(8'h12, S_ERR,  9'd0, 16'h0000);
        rst();
        by(8'h01, S_LOAD, 9'd0, 16'h0000);
        by(8'h01, S_ERR,  9'd0, 16'h0000);
        rst();
        by(8'h01, S_LOAD, 9'd0, 16'h0000);
        by(8'h00, S_LOAD, 9'd0, 16'h0000);

        // D: rx_valid toggling, idle bytes must not be consumed
        rst();
        by(8'h00, S_LOAD, 9'd0, 16'h0000);
        by(8'h02, S_LOAD, 9'd0, 16'h0000);
        by(8'h12, S_LOAD, 9'd0, 16'h0000);
        idle(8'hFF, S_LOAD, 9'd0, 16'h0000);
        by(8'h34, S_LOAD, 9'd1, 16'h1234);
        idle(8'h99, S_LOAD, 9'd1, 16'h1234);
        by(8'hAB, S_LOAD, 9'd1, 16'h1234);
        idle(8'h77, S_LOAD, 9'd1, 16'h1234);
`ifdef CHECKSUM_EN
        by(8'hCD, S_LOAD, 9'd2, 16'h1234);
        by(8'h40, S_RUN,  9'd2, 16'h1234);
`else
        by(8'hCD, S_RUN,  9'd2, 16'h1234);
`endif
        rd(16'd1, S_RUN, 9'd2, 16'hABCD);

        // E: reset mid-load (with a valid byte present), then a fresh image
        rst();
        by(8'h00, S_LOAD, 9'd0, 16'h0000);
        by(8'h02, S_LOAD, 9'd0, 16'h0000);
        by(8'h12, S_LOAD, 9'd0, 16'h0000);
        by(8'h34, S_LOAD, 9'd1, 16'h1234);
        by(8'hAB, S_LOAD, 9'd1, 16'h1234);
        pv(1'b0, 1'b1, 8'hEE, 16'h0000, S_LOAD, 9'd0, 16'h0000);
        pv(1'b1, 1'b0, 8'h00, 16'h0000, S_LOAD, 9'd0, 16'h0000);
        by(8'h00, S_LOAD, 9'd0, 16'h0000);
        by(8'h01, S_LOAD, 9'd0, 16'h0000);
        by(8'h55, S_LOAD, 9'd0, 16'h0000);
`ifdef CHECKSUM_EN
        by(8'hAA, S_LOAD, 9'd1, 16'h55AA);
        by(8'hFF, S_RUN,  9'd1, 16'h55AA);
`else
        by(8'hAA, S_RUN,  9'd1, 16'h55AA);
`endif
        rd(16'd1, S_RUN, 9'd1, 16'h0000);

        // F: bytes in RUN are ignored
        by(8'h77, S_RUN, 9'd1, 16'h55AA);
        by(8'h88, S_RUN, 9'd1, 16'h55AA);
        rd(16'd0, S_RUN, 9'd1, 16'h55AA);

        for (int i = 0; i < vq.size(); i++) begin
            logic [28:0] act;
            logic [28:0] exp;
            @(negedge clk);
            reset       = vq[i].rst_n;
            rx_valid    = vq[i].vld;
            rx_data     = vq[i].d;
            address_bus = vq[i].a;
            @(posedge clk);
            #1;
            act = {rx_ready, cpu_reset, load_done, load_err, words_loaded, data_bus};
            exp = {st_flags(vq[i].st), vq[i].words, vq[i].q};
            vec_cnt++;
            if (act !== exp) begin
                err_cnt++;
                $display("FAIL vec%0d: got rdy/cpu_rst/done/err=%b words=%0d data=%h, expected %b words=%0d data=%h",
                         i, act[28:25], act[24:16], act[15:0], exp[28:25], exp[24:16], exp[15:0]);
            end
        end
        rx_valid = 1'b0;

        // Zero-latency read: address change without a clock edge
        @(negedge clk);
        address_bus = 16'd1;
        #1 check16("comb_rd_addr1", data_bus, 16'h0000);
        address_bus = 16'd0;
        #1 check16("comb_rd_addr0", data_bus, 16'h55AA);

        // Full-depth image: 256 words
        @(negedge clk);
        reset = 1'b0; rx_valid = 1'b0;
        @(posedge clk);
        #1;
        send(8'h01);
        send(8'h00);
        csum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            hi = 8'(i);
            lo = ~hi;
            send(hi);
            send(lo);
            csum = csum ^ hi ^ lo;
        end
        check16("full_words", {7'd0, words_loaded}, 16'd256);
`ifdef CHECKSUM_EN
        check16("full_chk_ready", {15'd0, rx_ready}, 16'd1);
        send(csum);
`endif
        check16("full_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        @(negedge clk);
        address_bus = 16'd255;
        #1 check16("full_rd_255", data_bus, 16'hFF00);
        address_bus = 16'd128;
        #1 check16("full_rd_128", data_bus, 16'h807F);
        address_bus = 16'd256;
        #1 check16("full_rd_256", data_bus, 16'h0000);
        address_bus = 16'hFFFF;
        #1 check16("full_rd_ffff", data_bus, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
